// File: rtl/if_id_pkg.sv
// Shared opcode/funct constants and immediate-extension helper for the
// fetch/decode stage of the single-clock MIPS datapath.
package if_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Logical immediates are zero-extended; every other opcode sign-extends.
    function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] res;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: res = {16'h0000, imm};
            default:                  res = {{16{imm[15]}}, imm};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/if_id_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// synchronous clear. Register 0 is hardwired to zero.
module if_id_regfile
    import if_id_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs_r [32];

    // Register storage: clear on reset, otherwise write any register but 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_r[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_r[raddr2];

endmodule

// File: rtl/if_id.sv
// Instruction fetch + decode stage: program counter, writable instruction
// memory, next-PC select, register-file write decode and immediate extension.
module if_id
    import if_id_pkg::*;
#(
    parameter int IM_AW = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] newPC,
    input  logic [31:0] W_Ins,
    input  logic        WE,
    input  logic [31:0] Wdata,
    output logic [31:0] PC,
    output logic [31:0] nextPC,
    output logic [31:0] Ins,
    output logic [31:0] Rdata1,
    output logic [31:0] Rdata2,
    output logic [31:0] Ed32
);

    localparam int IM_DEPTH = 1 << IM_AW;

    logic [31:0]      pc_r;
    logic [31:0]      imem_r [IM_DEPTH];
    logic [IM_AW-1:0] im_idx_s;
    logic [31:0]      pc_sel_s;
    logic             rf_we_s;
    logic [4:0]       rf_waddr_s;
    logic [5:0]       op_s;
    logic [5:0]       funct_s;
    logic             regs_eq_s;
    logic             unused_pc_bits_s;

    assign im_idx_s         = pc_r[IM_AW+1:2];
    assign unused_pc_bits_s = ^{pc_r[31:IM_AW+2], pc_r[1:0]};

    assign PC     = pc_r;
    assign nextPC = pc_r + 32'd4;
    assign Ins    = imem_r[im_idx_s];
    assign Ed32   = ext_imm(op_s, Ins[15:0]);

    assign op_s      = Ins[31:26];
    assign funct_s   = Ins[5:0];
    assign regs_eq_s = (Rdata1 == Rdata2);

    // Next-PC select and register-file write-address decode.
    always_comb begin
        pc_sel_s   = nextPC;
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        case (op_s)
            OP_RTYPE: begin
                if (funct_s == FN_JR) begin
                    pc_sel_s = newPC;
                end else begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = Ins[15:11];
                end
            end
            OP_J: begin
                pc_sel_s = newPC;
            end
            OP_JAL: begin
                pc_sel_s   = newPC;
                rf_we_s    = 1'b1;
                rf_waddr_s = LINK_REG;
            end
            OP_BEQ: begin
                if (regs_eq_s) begin
                    pc_sel_s = newPC;
                end else begin
                    pc_sel_s = nextPC;
                end
            end
            OP_BNE: begin
                if (!regs_eq_s) begin
                    pc_sel_s = newPC;
                end else begin
                    pc_sel_s = nextPC;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = Ins[20:16];
            end
            default: begin
                pc_sel_s = nextPC;
            end
        endcase
    end

    // Program counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= pc_sel_s;
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (!RST && WE) begin
            imem_r[im_idx_s] <= W_Ins;
        end
    end

    if_id_regfile u_regfile (
        .clk    (CLK),
        .rst    (RST),
        .we     (rf_we_s),
        .waddr  (rf_waddr_s),
        .wdata  (Wdata),
        .raddr1 (Ins[25:21]),
        .raddr2 (Ins[20:16]),
        .rdata1 (Rdata1),
        .rdata2 (Rdata2)
    );

endmodule

// File: tb/tb_if_id.sv
// Directed, table-driven bench for if_id: loads a short program, replays it
// against hand-computed vectors, then checks a mid-run reset.
module tb_if_id;

    logic        CLK;
    logic        RST;
    logic [31:0] newPC;
    logic [31:0] W_Ins;
    logic        WE;
    logic [31:0] Wdata;
    logic [31:0] PC;
    logic [31:0] nextPC;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;

    if_id #(.IM_AW(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .newPC  (newPC),
        .W_Ins  (W_Ins),
        .WE     (WE),
        .Wdata  (Wdata),
        .PC     (PC),
        .nextPC (nextPC),
        .Ins    (Ins),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Ed32   (Ed32)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] new_pc;
        logic [31:0] wdata;
        logic [31:0] ins;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ed;
        logic [31:0] pc_next;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] prog [20];
    logic [31:0] exp_pc;
    int          n_checks;
    int          n_fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        for (int i = 0; i < 20; i++) prog[i] = 32'h0000_0000;
        prog[0]  = 32'h2001_000A;  // addi $1,$0,10
        prog[1]  = 32'h0021_1020;  // add  $2,$1,$1
        prog[2]  = 32'h2002_FFFF;  // addi $2,$0,-1
        prog[3]  = 32'h3403_FFFF;  // ori  $3,$0,0xFFFF
        prog[4]  = 32'h2000_0005;  // addi $0,$0,5
        prog[5]  = 32'h1001_0007;  // beq  $0,$1 (not taken)
        prog[6]  = 32'h1021_0000;  // beq  $1,$1 (taken)
        prog[8]  = 32'h0800_0010;  // j
        prog[16] = 32'h0C00_0000;  // jal
        prog[18] = 32'h03FF_0020;  // add  $0,$31,$31
        prog[19] = 32'h1423_0000;  // bne  $1,$3 (taken)

        //          pc            newPC         Wdata         Ins           Rdata1        Rdata2        Ed32          PC after edge
        vecs[0]  = '{32'h00, 32'h0000_0000, 32'h0000_000A, 32'h2001_000A, 32'h0, 32'h0, 32'h0000_000A, 32'h04};
        vecs[1]  = '{32'h04, 32'h0000_0000, 32'h0000_0014, 32'h0021_1020, 32'd10, 32'd10, 32'h0000_1020, 32'h08};
        vecs[2]  = '{32'h08, 32'h0000_0000, 32'h0000_0014, 32'h2002_FFFF, 32'h0, 32'd20, 32'hFFFF_FFFF, 32'h0C};
        vecs[3]  = '{32'h0C, 32'h0000_0000, 32'h0000_FFFF, 32'h3403_FFFF, 32'h0, 32'h0, 32'h0000_FFFF, 32'h10};
        vecs[4]  = '{32'h10, 32'h0000_0000, 32'hDEAD_BEEF, 32'h2000_0005, 32'h0, 32'h0, 32'h0000_0005, 32'h14};
        vecs[5]  = '{32'h14, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1001_0007, 32'h0, 32'd10, 32'h0000_0007, 32'h18};
        vecs[6]  = '{32'h18, 32'h0000_0020, 32'h0000_0000, 32'h1021_0000, 32'd10, 32'd10, 32'h0000_0000, 32'h20};
        vecs[7]  = '{32'h20, 32'h0000_0040, 32'h0000_0000, 32'h0800_0010, 32'h0, 32'h0, 32'h0000_0010, 32'h40};
        vecs[8]  = '{32'h40, 32'h0000_0048, 32'h0000_0044, 32'h0C00_0000, 32'h0, 32'h0, 32'h0000_0000, 32'h48};
        vecs[9]  = '{32'h48, 32'h0000_0100, 32'hDEAD_BEEF, 32'h03FF_0020, 32'h44, 32'h44, 32'h0000_0020, 32'h4C};
        vecs[10] = '{32'h4C, 32'h0000_0010, 32'h0000_0000, 32'h1423_0000, 32'd10, 32'h0000_FFFF, 32'h0000_0000, 32'h10};

        // Reset held for two edges.
        RST   = 1'b1;
        WE    = 1'b0;
        W_Ins = 32'h0;
        newPC = 32'h0;
        Wdata = 32'h0;
        tick();
        tick();
        check("reset_pc", PC, 32'h0);
        check("reset_nextpc", nextPC, 32'h4);
        check("reset_rdata1", Rdata1, 32'h0);
        check("reset_rdata2", Rdata2, 32'h0);

        // Sequential program load; newPC tracks PC+4 so undefined memory
        // contents cannot redirect the load.
        RST    = 1'b0;
        WE     = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            W_Ins = prog[i];
            newPC = exp_pc + 32'd4;
            tick();
            exp_pc = exp_pc + 32'd4;
            check("load_pc", PC, exp_pc);
        end
        WE  = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("reload_pc", PC, 32'h0);

        // Replay the program against the vector table.
        for (int i = 0; i < 11; i++) begin
            newPC = vecs[i].new_pc;
            Wdata = vecs[i].wdata;
            #1;
            check("vec_pc", PC, vecs[i].pc);
            check("vec_nextpc", nextPC, vecs[i].pc + 32'd4);
            check("vec_ins", Ins, vecs[i].ins);
            check("vec_rdata1", Rdata1, vecs[i].rd1);
            check("vec_rdata2", Rdata2, vecs[i].rd2);
            check("vec_ed32", Ed32, vecs[i].ed);
            tick();
            check("vec_pc_after", PC, vecs[i].pc_next);
        end

        // Mid-run reset at PC 0x10 with an instruction write pending.
        RST   = 1'b1;
        WE    = 1'b1;
        W_Ins = 32'hFFFF_FFFF;
        Wdata = 32'hDEAD_BEEF;
        newPC = 32'h0000_0080;
        #1;
        check("midrst_pc_before", PC, 32'h10);
        check("midrst_ins_before", Ins, 32'h2000_0005);
        tick();
        RST   = 1'b0;
        WE    = 1'b0;
        Wdata = 32'h0;
        newPC = 32'h0;
        #1;
        check("midrst_pc", PC, 32'h0);
        check("midrst_nextpc", nextPC, 32'h4);
        check("midrst_ins0", Ins, 32'h2001_000A);
        check("midrst_r1_cleared", Rdata2, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("midrst_walk_pc", PC, 32'(k * 4));
            check("midrst_walk_ins", Ins, prog[k]);
            if (k == 3) check("midrst_r3_cleared", Rdata2, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
